// File: rtl/arb_pkg.sv
// Shared arbiter types and the rotate/priority-encode winner search.
package arb_pkg;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // First set bit of r at or after index p (wrapping); result is meaningless if r == 0.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  p);
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      logic [ID_W-1:0]    enc;
      dbl = {r, r} >> p;
      rot = dbl[N_REQ-1:0];
      enc = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rot[i]) enc = ID_W'(i);
      return enc + p;
   endfunction
endpackage

// File: rtl/decoder2x4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder2x4 (
   input  logic [1:0] A,
   input  logic       En,
   output logic [3:0] Y
);
   assign Y = En ? (4'b0001 << A) : 4'b0000;
endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: grant hold while requested, bounded tenure
// under contention, direct hand-over on release.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             preempt
);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_t         state_q;
   logic [ID_W-1:0]    gnt_id_q, ptr_q;
   logic [HOLD_W-1:0]  hold_q;
   logic               preempt_q;

   logic [N_REQ-1:0]   others, cand;
   logic               own_req;
   logic [ID_W-1:0]    win_id;

   // Candidates exclude the current owner so expiry and release never re-pick it.
   always_comb begin
      others  = req & ~(N_REQ'(1) << gnt_id_q);
      own_req = req[gnt_id_q];
      cand    = (state_q == GRANT) ? others : req;
      win_id  = rr_pick(cand, ptr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q  <= GRANT;
                  gnt_id_q <= win_id;
                  ptr_q    <= win_id + 1'b1;
                  hold_q   <= '0;
               end
            end
            GRANT: begin
               if (own_req && (hold_q != HOLD_LAST || others == '0)) begin
                  if (hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
               end else if (others != '0) begin
                  // Owner still requesting here means tenure expired.
                  gnt_id_q  <= win_id;
                  ptr_q     <= win_id + 1'b1;
                  hold_q    <= '0;
                  preempt_q <= own_req;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_id    = gnt_id_q;
   assign gnt_valid = (state_q == GRANT);
   assign preempt   = preempt_q;

   decoder2x4 u_dec (
      .A  (gnt_id_q),
      .En (gnt_valid),
      .Y  (gnt)
   );
endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: per-cycle comparison against a tenure-counting
// behavioural model, plus directed vectors with literal expectations.
module tb_rr_arbiter4;
   localparam int MH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int total = 0;
   int bad   = 0;

   rr_arbiter4 #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   // Model: owner, favoured index, and how many cycles the owner has held so far.
   int m_own = 0, m_ptr = 0, m_ten = 0;
   bit m_v = 1'b0, m_pre = 1'b0;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [3:0] oth;
      int         w;
      if (!rst_n) begin
         m_own = 0; m_ptr = 0; m_ten = 0; m_v = 1'b0; m_pre = 1'b0;
      end else begin
         m_pre = 1'b0;
         oth = req;
         if (m_v) oth[m_own] = 1'b0;
         w = -1;
         if (!m_v) begin
            if (req != 4'b0) w = pick(req, m_ptr);
         end else if (req[m_own] && (m_ten < MH || oth == 4'b0)) begin
            m_ten = m_ten + 1;
         end else if (oth != 4'b0) begin
            m_pre = req[m_own];
            w = pick(oth, m_ptr);
         end else begin
            m_v = 1'b0;
         end
         if (w >= 0) begin
            m_own = w; m_ptr = (w + 1) % 4; m_ten = 1; m_v = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] outs();
      return {gnt, gnt_id, gnt_valid, preempt};
   endfunction

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      logic [3:0] eg;
      eg = m_v ? 4'(1 << m_own) : 4'b0000;
      chk("model", outs(), {eg, 2'(m_own), m_v, m_pre});
      total++;
      if ($countones(gnt) > 1) begin
         bad++;
         $display("FAIL onehot: got %b want at most one bit", gnt);
      end
   end

   task automatic drive(input logic [3:0] r);
      req = r;
      @(negedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1 chk("reset_state", outs(), 8'b0000_00_0_0);

      rst_n = 1'b1;
      drive(4'b0100);
      chk("first_grant", outs(), 8'b0100_10_1_0);

      #2 rst_n = 1'b0;
      #1 chk("async_reset", outs(), 8'b0000_00_0_0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1 chk("post_reset_grant", outs(), 8'b0100_10_1_0);

      for (int c = 0; c < 20; c++) begin
         drive(4'b0010);
         chk("lone_holder", outs(), 8'b0010_01_1_0);
      end

      drive(4'b0000);
      chk("all_idle", outs(), 8'b0000_01_0_0);

      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int c = 0; c <= 4 * MH; c++) begin
         int id;
         id = (c / MH) % 4;
         drive(4'b1111);
         chk("contention", outs(), {4'(1 << id), 2'(id), 1'b1, (c > 0 && c % MH == 0)});
      end

      drive(4'b0001);
      chk("handoff_hold", outs(), 8'b0001_00_1_0);
      drive(4'b1000);
      chk("handoff", outs(), 8'b1000_11_1_0);

      drive(4'b0100);
      chk("fair_id2", outs(), 8'b0100_10_1_0);
      drive(4'b1011);
      chk("fair_id3", outs(), 8'b1000_11_1_0);
      drive(4'b0011);
      chk("fair_id0", outs(), 8'b0001_00_1_0);
      drive(4'b0010);
      chk("fair_id1", outs(), 8'b0010_01_1_0);
      drive(4'b0000);
      chk("final_idle", outs(), 8'b0000_01_0_0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
